// File: rtl/fetch_controller_pkg.sv
// ---------------------------------------------------------------------------
// fetch_controller_pkg
//   Shared definitions for the instruction fetch front end: datapath width,
//   the fetch FSM state encoding, the fetch-buffer entry layout and a small
//   address alignment helper.
// ---------------------------------------------------------------------------
package fetch_controller_pkg;

    localparam int XLEN = 32;

    // Fetch FSM states. At most one memory request is ever outstanding; DROP
    // waits out a response that belongs to a stream killed by a redirect.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the two byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Small synchronous FIFO holding fetched instructions until decode takes
//   them. A flush empties it on the next clock edge and overrides any push or
//   pop in the same cycle.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (empties the FIFO)
//   i_flush      in   discard all entries
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   entry to write ({pc, instr})
//   i_pop        in   remove the head entry
//   o_head_data  out  head entry (valid when o_empty is low)
//   o_empty      out  no entries held
//   o_count      out  number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_controller_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_flush,
    input  logic                             i_push,
    input  logic [$bits(fetch_entry_t)-1:0]  i_push_data,
    input  logic                             i_pop,
    output logic [$bits(fetch_entry_t)-1:0]  o_head_data,
    output logic                             o_empty,
    output logic [$clog2(DEPTH):0]           o_count
);

    localparam int ENTRY_W = $bits(fetch_entry_t);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;
    logic w_full;
    logic w_empty;

    // Occupancy flags. DEPTH is a power of two, so the pointers wrap on
    // their own and only the counter distinguishes full from empty.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle. Flush wins over both.
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    // Pointer and occupancy bookkeeping; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: nothing is read until the counter says
    // the slot has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_empty     = w_empty;
    assign o_count     = r_count;

endmodule

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Instruction fetch front end. Issues one word-aligned request at a time to
//   instruction memory, queues returned instructions in a small buffer for
//   decode, and handles redirects (taken branches/jumps) by flushing the
//   buffer and discarding any response still in flight for the old stream.
//
// Parameters
//   RESET_VECTOR    first fetch address after reset
//   BUF_DEPTH       fetch buffer entries (power of two, >= 2)
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   redirect_valid  in   redirect from EX this cycle
//   redirect_pc     in   redirect target (low two bits ignored)
//   imem_req        out  memory request
//   imem_addr       out  request address (word aligned)
//   imem_gnt        in   memory accepted the request this cycle
//   imem_rvalid     in   response valid (one per grant, in order)
//   imem_rdata      in   response instruction word
//   if_valid        out  head instruction available to decode
//   if_instr        out  head instruction
//   if_pc           out  address of head instruction
//   if_pc_plus_4    out  if_pc + 4 (wraps modulo 2^32)
//   if_ready        in   decode consumes the head this cycle
// ---------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    input  logic        if_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;

    fetch_state_e    w_state_next;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [XLEN-1:0] w_req_pc_next;

    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_empty;
    logic [CNT_W-1:0] w_count;
    logic            w_room_now;
    logic            w_room_after_push;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Room checks. Outside WAIT nothing is outstanding, so room is simply a
    // free buffer slot. In WAIT the in-flight response will take a slot, so
    // the decision to issue the next request is made after accounting for
    // the push and any simultaneous pop.
    assign w_room_now        = (w_count < DEPTH_C);
    assign w_room_after_push = w_pop ? (w_count < DEPTH_C)
                                     : ((w_count + CNT_W'(1)) < DEPTH_C);

    // Next-state logic. A redirect overrides every other event: the fetch
    // address is replaced, and the state only depends on whether a request
    // for the old stream is (or is about to be) in flight and must be
    // drained in DROP.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_req_pc_next   = r_req_pc;

        if (redirect_valid) begin
            w_fetch_pc_next = word_align(redirect_pc);
            case (r_state)
                ST_IDLE: w_state_next = ST_REQ;
                ST_REQ:  w_state_next = imem_gnt ? ST_DROP : ST_REQ;
                ST_WAIT: w_state_next = imem_rvalid ? ST_REQ : ST_DROP;
                ST_DROP: w_state_next = imem_rvalid ? ST_REQ : ST_DROP;
                default: w_state_next = ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_room_now) begin
                        w_state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        w_state_next    = ST_WAIT;
                        w_req_pc_next   = r_fetch_pc;
                        w_fetch_pc_next = r_fetch_pc + XLEN'(4);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_next = w_room_after_push ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State registers. After reset the FSM sits in IDLE, so any response
    // arriving from a pre-reset request is simply never pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= word_align(RESET_VECTOR);
            r_req_pc   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_req_pc   <= w_req_pc_next;
        end
    end

    // The request is presented for the whole of REQ, including a redirect
    // cycle; if memory grants it then, the response is drained in DROP.
    assign imem_req  = (r_state == ST_REQ);
    assign imem_addr = r_fetch_pc;

    // Only a response for a live request is queued; a redirect in the same
    // cycle flushes the buffer instead.
    assign w_push            = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = imem_rdata;
    assign w_flush           = redirect_valid;

    // The head is hidden from decode while a redirect is active so nothing
    // from the wrong path is consumed in that cycle.
    assign if_valid     = !w_empty && !redirect_valid;
    assign w_pop        = if_valid && if_ready;
    assign if_instr     = w_head.instr;
    assign if_pc        = w_head.pc;
    assign if_pc_plus_4 = w_head.pc + XLEN'(4);

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//   Directed bench for fetch_controller. Instance A uses the default reset
//   vector and a controllable memory model; instance B uses a reset vector
//   near the top of the address space with a zero-wait memory.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic [31:0] ifPcPlus4;
    logic        ifReady;

    logic        gntEn;
    logic        rvEn;
    logic        memFlush;
    logic        memPend;
    logic [31:0] memAddr;

    logic        resetB;
    logic        redirectValidB;
    logic [31:0] redirectPcB;
    logic        imemReqB;
    logic [31:0] imemAddrB;
    logic        imemGntB;
    logic        imemRvalidB;
    logic [31:0] imemRdataB;
    logic        ifValidB;
    logic [31:0] ifInstrB;
    logic [31:0] ifPcB;
    logic [31:0] ifPcPlus4B;
    logic        ifReadyB;
    logic        pendB;
    logic [31:0] addrB;

    int testsRun    = 0;
    int testsFailed = 0;

    fetch_controller dutA (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_gnt       (imemGnt),
        .imem_rvalid    (imemRvalid),
        .imem_rdata     (imemRdata),
        .if_valid       (ifValid),
        .if_instr       (ifInstr),
        .if_pc          (ifPc),
        .if_pc_plus_4   (ifPcPlus4),
        .if_ready       (ifReady)
    );

    fetch_controller #(
        .RESET_VECTOR (32'hFFFF_FFF8)
    ) dutB (
        .clk            (clk),
        .reset          (resetB),
        .redirect_valid (redirectValidB),
        .redirect_pc    (redirectPcB),
        .imem_req       (imemReqB),
        .imem_addr      (imemAddrB),
        .imem_gnt       (imemGntB),
        .imem_rvalid    (imemRvalidB),
        .imem_rdata     (imemRdataB),
        .if_valid       (ifValidB),
        .if_instr       (ifInstrB),
        .if_pc          (ifPcB),
        .if_pc_plus_4   (ifPcPlus4B),
        .if_ready       (ifReadyB)
    );

    // Instruction word stored at an address: easy to recognise by eye.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory A: grants whenever gntEn allows, answers one cycle later or
    // later still while rvEn is held low. It is not reset by the DUT reset so
    // a pre-reset response can arrive late.
    assign imemGnt    = imemReq & gntEn;
    assign imemRvalid = memPend & rvEn;
    assign imemRdata  = instrOf(memAddr);

    always @(posedge clk) begin
        if (memFlush) begin
            memPend <= 1'b0;
        end else if (imemReq && imemGnt) begin
            memPend <= 1'b1;
            memAddr <= imemAddr;
        end else if (imemRvalid) begin
            memPend <= 1'b0;
        end
    end

    // Memory B: zero-wait, grant in the request cycle, data the next cycle.
    assign imemGntB    = imemReqB;
    assign imemRvalidB = pendB;
    assign imemRdataB  = instrOf(addrB);

    always @(posedge clk) begin
        if (resetB) begin
            pendB <= 1'b0;
        end else if (imemReqB && imemGntB) begin
            pendB <= 1'b1;
            addrB <= imemAddrB;
        end else if (pendB) begin
            pendB <= 1'b0;
        end
    end

    // Holds reset for two edges and releases it on a falling edge, leaving
    // the caller in the first post-reset (IDLE) cycle.
    task automatic applyReset(input bit flushMem);
        @(negedge clk);
        reset    = 1'b1;
        memFlush = flushMem;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        memFlush = 1'b0;
    endtask

    task automatic test_reset();
        gntEn = 1'b1; rvEn = 1'b1; ifReady = 1'b1;
        redirectValid = 1'b0; redirectPc = 32'h0;
        @(negedge clk);
        reset = 1'b1; memFlush = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_req: got %b want 0", imemReq);
        end
        testsRun++;
        if (ifValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_if_valid: got %b want 0", ifValid);
        end
        reset = 1'b0; memFlush = 1'b0;
        #1;
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL idle_after_reset_req: got %b want 0", imemReq);
        end
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", imemReq, imemAddr);
        end
    endtask

    // Continues straight from test_reset (second post-reset cycle, REQ 0x0).
    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if (imemReq !== 1'b1 || imemAddr !== 32'(4 * k)) begin
                testsFailed++;
                $display("[TB] FAIL zw_req_%0d: got req=%b addr=%h want req=1 addr=%h", k, imemReq, imemAddr, 32'(4 * k));
            end
            if (k >= 1) begin
                testsRun++;
                if (ifValid !== 1'b1 || ifPc !== 32'(4 * (k - 1)) || ifInstr !== instrOf(32'(4 * (k - 1)))
                    || ifPcPlus4 !== 32'(4 * k)) begin
                    testsFailed++;
                    $display("[TB] FAIL zw_head_%0d: got v=%b pc=%h instr=%h p4=%h want v=1 pc=%h instr=%h p4=%h",
                             k, ifValid, ifPc, ifInstr, ifPcPlus4, 32'(4 * (k - 1)), instrOf(32'(4 * (k - 1))), 32'(4 * k));
                end
            end
            @(negedge clk);
            testsRun++;
            if (imemReq !== 1'b0 || ifValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL zw_wait_%0d: got req=%b v=%b want req=0 v=0", k, imemReq, ifValid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        ifReady = 1'b0; gntEn = 1'b1; rvEn = 1'b1;
        applyReset(1'b1);
        for (int c = 1; c <= 12; c++) begin
            if (c >= 6) begin
                testsRun++;
                if (imemReq !== 1'b0 || ifValid !== 1'b1 || ifPc !== 32'h0) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_hold_c%0d: got req=%b v=%b pc=%h want req=0 v=1 pc=00000000", c, imemReq, ifValid, ifPc);
                end
            end
            @(negedge clk);
        end
        ifReady = 1'b1;
        #1;
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInstr !== 32'hC0DE_0000) begin
            testsFailed++;
            $display("[TB] FAIL stall_drain0: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=c0de0000", ifValid, ifPc, ifInstr);
        end
        @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInstr !== 32'hC0DE_0004) begin
            testsFailed++;
            $display("[TB] FAIL stall_drain1: got v=%b pc=%h instr=%h want v=1 pc=00000004 instr=c0de0004", ifValid, ifPc, ifInstr);
        end
        @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h8) begin
            testsFailed++;
            $display("[TB] FAIL stall_resume: got v=%b req=%b addr=%h want v=0 req=1 addr=00000008", ifValid, imemReq, imemAddr);
        end
    endtask

    task automatic test_redirect_wait();
        ifReady = 1'b1; gntEn = 1'b1; rvEn = 1'b0;
        applyReset(1'b1);
        @(negedge clk);
        @(negedge clk);
        redirectValid = 1'b1; redirectPc = 32'h0000_0103;
        #1;
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rw_wait_req: got %b want 0", imemReq);
        end
        @(negedge clk);
        redirectValid = 1'b0; rvEn = 1'b1;
        #1;
        testsRun++;
        if (imemReq !== 1'b0 || ifValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rw_drop: got req=%b v=%b want req=0 v=0", imemReq, ifValid);
        end
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h100 || ifValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rw_new_req: got req=%b addr=%h v=%b want req=1 addr=00000100 v=0", imemReq, imemAddr, ifValid);
        end
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h100 || ifInstr !== 32'hC0DE_0100) begin
            testsFailed++;
            $display("[TB] FAIL rw_head: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=c0de0100", ifValid, ifPc, ifInstr);
        end
    endtask

    task automatic test_redirect_gnt();
        ifReady = 1'b0; gntEn = 1'b1; rvEn = 1'b1;
        applyReset(1'b1);
        repeat (3) @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL rg_before: got v=%b pc=%h want v=1 pc=00000000", ifValid, ifPc);
        end
        redirectValid = 1'b1; redirectPc = 32'h0000_0200;
        #1;
        testsRun++;
        if (ifValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h4) begin
            testsFailed++;
            $display("[TB] FAIL rg_gate: got v=%b req=%b addr=%h want v=0 req=1 addr=00000004", ifValid, imemReq, imemAddr);
        end
        @(negedge clk);
        redirectValid = 1'b0; ifReady = 1'b1;
        #1;
        testsRun++;
        if (imemReq !== 1'b0 || ifValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rg_drop: got req=%b v=%b want req=0 v=0", imemReq, ifValid);
        end
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h200 || ifValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rg_new_req: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", imemReq, imemAddr, ifValid);
        end
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h200 || ifInstr !== 32'hC0DE_0200 || ifPcPlus4 !== 32'h204) begin
            testsFailed++;
            $display("[TB] FAIL rg_head: got v=%b pc=%h instr=%h p4=%h want v=1 pc=00000200 instr=c0de0200 p4=00000204",
                     ifValid, ifPc, ifInstr, ifPcPlus4);
        end
    endtask

    task automatic test_redirect_req();
        ifReady = 1'b1; gntEn = 1'b0; rvEn = 1'b1;
        applyReset(1'b1);
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL rq_hold: got req=%b addr=%h want req=1 addr=00000000", imemReq, imemAddr);
        end
        redirectValid = 1'b1; redirectPc = 32'h0000_0304;
        @(negedge clk);
        redirectValid = 1'b0;
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h304) begin
            testsFailed++; $display("[TB] FAIL rq_new_addr: got req=%b addr=%h want req=1 addr=00000304", imemReq, imemAddr);
        end
        gntEn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h304) begin
            testsFailed++; $display("[TB] FAIL rq_head: got v=%b pc=%h want v=1 pc=00000304", ifValid, ifPc);
        end
    endtask

    task automatic test_wrap();
        ifReadyB = 1'b1; redirectValidB = 1'b0; redirectPcB = 32'h0;
        @(negedge clk);
        resetB = 1'b1;
        repeat (2) @(negedge clk);
        resetB = 1'b0;
        @(negedge clk);
        testsRun++;
        if (imemReqB !== 1'b1 || imemAddrB !== 32'hFFFF_FFF8) begin
            testsFailed++; $display("[TB] FAIL wrap_req0: got req=%b addr=%h want req=1 addr=fffffff8", imemReqB, imemAddrB);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if (imemAddrB !== 32'hFFFF_FFFC || ifValidB !== 1'b1 || ifPcB !== 32'hFFFF_FFF8
            || ifInstrB !== 32'hC0DE_FFF8 || ifPcPlus4B !== 32'hFFFF_FFFC) begin
            testsFailed++;
            $display("[TB] FAIL wrap_step1: got addr=%h v=%b pc=%h instr=%h p4=%h want addr=fffffffc v=1 pc=fffffff8 instr=c0defff8 p4=fffffffc",
                     imemAddrB, ifValidB, ifPcB, ifInstrB, ifPcPlus4B);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if (imemAddrB !== 32'h0 || ifPcB !== 32'hFFFF_FFFC || ifPcPlus4B !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_step2: got addr=%h pc=%h p4=%h want addr=00000000 pc=fffffffc p4=00000000", imemAddrB, ifPcB, ifPcPlus4B);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if (ifValidB !== 1'b1 || ifPcB !== 32'h0 || ifPcPlus4B !== 32'h4) begin
            testsFailed++;
            $display("[TB] FAIL wrap_step3: got v=%b pc=%h p4=%h want v=1 pc=00000000 p4=00000004", ifValidB, ifPcB, ifPcPlus4B);
        end
        resetB = 1'b1;
    endtask

    task automatic test_reset_wait();
        ifReady = 1'b1; gntEn = 1'b1; rvEn = 1'b1;
        applyReset(1'b1);
        repeat (3) @(negedge clk);
        rvEn = 1'b0;
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b0 || ifValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rst_wait_state: got req=%b v=%b want req=0 v=0", imemReq, ifValid);
        end
        applyReset(1'b0);
        rvEn = 1'b1;
        #1;
        testsRun++;
        if (imemReq !== 1'b0 || ifValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rst_late_idle: got req=%b v=%b want req=0 v=0", imemReq, ifValid);
        end
        @(negedge clk);
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0 || ifValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_late_ignored: got req=%b addr=%h v=%b want req=1 addr=00000000 v=0", imemReq, imemAddr, ifValid);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInstr !== 32'hC0DE_0000) begin
            testsFailed++;
            $display("[TB] FAIL rst_restart_head: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=c0de0000", ifValid, ifPc, ifInstr);
        end
    endtask

    initial begin
        reset = 1'b1; memFlush = 1'b1; gntEn = 1'b0; rvEn = 1'b0;
        redirectValid = 1'b0; redirectPc = 32'h0; ifReady = 1'b0;
        resetB = 1'b1; redirectValidB = 1'b0; redirectPcB = 32'h0; ifReadyB = 1'b0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_req();
        test_wrap();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
